// File: rtl/btn_sched_pkg.sv
// Shared types and defaults for the button command scheduler.
// Holds the controller state enum, the default parameter values and the
// round-robin first-set search used to pick the next pending button.
package btn_sched_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    // Default configuration
    localparam int DEF_N_BTN         = 4;
    localparam int DEF_STABLE        = 9;
    localparam int DEF_ACK_TIMEOUT   = 255;
    localparam int DEF_REPEAT_PERIOD = 50;

    // Widest request vector the search function understands
    localparam int MAX_BTN = 8;

    // Returns the index of the first set bit of req, scanning upward from
    // ptr+1 and wrapping through 0..ptr. Only the low n bits take part.
    // When nothing is set the pointer itself is returned; callers only use
    // the result when at least one bit is set.
    function automatic int rr_first_set(
        input logic [MAX_BTN-1:0] req,
        input int                 ptr,
        input int                 n
    );
        int sel;
        sel = -1;
        // Lowest set bit strictly above the pointer
        for (int j = MAX_BTN - 1; j >= 0; j--) begin
            if ((j < n) && (j > ptr) && req[j]) begin
                sel = j;
            end
        end
        // Otherwise wrap and take the lowest set bit at or below the pointer
        if (sel < 0) begin
            for (int j = MAX_BTN - 1; j >= 0; j--) begin
                if ((j <= ptr) && req[j]) begin
                    sel = j;
                end
            end
        end
        if (sel < 0) begin
            sel = ptr;
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_press_filter.sv
// Per-button debounce filter.
// A STABLE+1 bit shift register samples the raw level each clock; a press
// is reported in the single cycle where the oldest sample is low and all
// STABLE newer samples are high, so a held button gives exactly one pulse.
// Optional feature macro: BTN_REPEAT_EN -- while the register stays all
// ones, an extra press is produced every REPEAT_PERIOD cycles after the
// initial press.
module btn_press_filter
    import btn_sched_pkg::*;
#(
    parameter int STABLE        = DEF_STABLE,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    logic [STABLE:0] shreg;
    logic            first_press;

    // Sample history: newest sample enters at bit 0
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else begin
            shreg <= {shreg[STABLE-1:0], btn_raw};
        end
    end

    // Rising edge of a debounced level: one low followed by STABLE highs
    assign first_press = ~shreg[STABLE] & (&shreg[STABLE-1:0]);

`ifdef BTN_REPEAT_EN
    localparam int RCNT_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

    logic              all_ones;
    logic [RCNT_W-1:0] rpt_cnt;
    logic              rpt_hit;

    assign all_ones = &shreg;
    assign rpt_hit  = all_ones & (rpt_cnt == RCNT_W'(REPEAT_PERIOD - 1));

    // Repeat counter: runs while the history is all ones, wraps on each
    // repeat event, and restarts whenever a low sample is taken
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rpt_cnt <= '0;
        end else if (!btn_raw || !all_ones || rpt_hit) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + RCNT_W'(1);
        end
    end

    assign press = first_press | rpt_hit;
`else
    // Repeat period has no effect in this build
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_PERIOD != 0);

    assign press = first_press;
`endif

endmodule

// File: rtl/btn_cmd_sched.sv
// Button command scheduler.
// Debounces N_BTN raw buttons into one-shot presses, keeps one pending
// command per button and grants them round-robin onto a single
// cmd_valid/cmd_ack port towards the processor control unit.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat inside each filter).
//
// Handshake: cmd_valid is raised together with a stable cmd_id and stays
// high until a clock edge where cmd_ack is also high (the transfer) or the
// ack timer expires. cmd_ack is ignored whenever cmd_valid is low. After
// every grant cmd_valid is low for at least one GAP cycle.
module btn_cmd_sched
    import btn_sched_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int STABLE        = DEF_STABLE,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_raw,
    input  logic                     cmd_ack,
    input  logic                     clear_err,
    output logic                     cmd_valid,
    output logic [$clog2(N_BTN)-1:0] cmd_id,
    output logic [N_BTN-1:0]         pending,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     drop_err
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_t       state;
    logic [ID_W-1:0]    rr_ptr;
    logic [TMR_W-1:0]   ack_tmr;

    logic [N_BTN-1:0]   press;
    logic [N_BTN-1:0]   clr_vec;
    logic [N_BTN-1:0]   drop_vec;
    logic               issue_ack;
    logic               tmr_expire;
    logic               issue_done;
    logic               timeout_hit;

    logic [MAX_BTN-1:0] req_ext;
    int                 pick_idx;
    logic [ID_W-1:0]    pick;

    // One debounce filter per button
    for (genvar g = 0; g < N_BTN; g++) begin : g_filt
        btn_press_filter #(
            .STABLE        (STABLE),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_filt (
            .clk_in  (clk_in),
            .reset   (reset),
            .btn_raw (btn_raw[g]),
            .press   (press[g])
        );
    end

    // The timer counts ISSUE cycles from 0, so the last allowed cycle is
    // the one where it reads ACK_TIMEOUT-1; an ack on that cycle still wins
    assign issue_ack   = (state == ISSUE) && cmd_ack;
    assign tmr_expire  = (state == ISSUE) && (ack_tmr == TMR_W'(ACK_TIMEOUT - 1));
    assign issue_done  = issue_ack || tmr_expire;
    assign timeout_hit = tmr_expire && !cmd_ack;

    // Pending bit released by the command that finishes this cycle
    always_comb begin
        clr_vec = '0;
        if (issue_done) begin
            clr_vec[cmd_id] = 1'b1;
        end
    end

    // A press on a bit that stays pending is lost; a press on the bit being
    // released in the same cycle simply re-arms it
    assign drop_vec = press & pending & ~clr_vec;

    // Round-robin choice among pending buttons, starting after the pointer
    always_comb begin
        req_ext               = '0;
        req_ext[N_BTN-1:0]    = pending;
        pick_idx              = rr_first_set(req_ext, int'(rr_ptr), N_BTN);
        pick                  = ID_W'(pick_idx);
    end

    // Grant controller: IDLE picks, ISSUE offers and waits, GAP idles a cycle
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            rr_ptr    <= ID_W'(N_BTN - 1);
            ack_tmr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        cmd_id    <= pick;
                        cmd_valid <= 1'b1;
                        ack_tmr   <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack_tmr <= ack_tmr + TMR_W'(1);
                    if (issue_done) begin
                        cmd_valid <= 1'b0;
                        rr_ptr    <= cmd_id;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Pending flags: set by presses, cleared when their command finishes
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | press;
        end
    end

    // Sticky error flags; a new error in the same cycle beats clear_err
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
            if (|drop_vec) begin
                drop_err <= 1'b1;
            end else if (clear_err) begin
                drop_err <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) || (|pending);

endmodule
